// File: rtl/uart_scon_bank.sv
// Multi-channel SCON register bank on the 8-bit SFR bus.
// Hardware-set TI/RI/RB8 flags, per-channel receive overrun detection, and a
// registered round-robin arbiter that reports one pending channel to the CPU.
module uart_scon_bank #(
  parameter int unsigned       NUM_CH    = 2,
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] SCON_BASE = 8'h98,
  parameter logic [ADDR_W-1:0] STAT_ADDR = 8'hA8,
  parameter logic [ADDR_W-1:0] ID_ADDR   = 8'hA9,
  parameter int unsigned       CHW       = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            din,
  input  logic [ADDR_W-1:0]     ab,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic [NUM_CH-1:0]     ti,
  input  logic [NUM_CH-1:0]     ri,
  input  logic [NUM_CH-1:0]     set_rb8,
  input  logic [NUM_CH-1:0]     rb8,
  output logic [7:0]            dout,
  output logic [2*NUM_CH-1:0]   sm,
  output logic [NUM_CH-1:0]     sm2,
  output logic [NUM_CH-1:0]     ren,
  output logic [NUM_CH-1:0]     tb8,
  output logic [NUM_CH-1:0]     scon_ri,
  output logic [NUM_CH-1:0]     int_ch,
  output logic                  int_uart,
  output logic [CHW-1:0]        int_id,
  output logic                  int_valid
);

  logic [7:0]        scon     [NUM_CH];
  logic [7:0]        scon_nxt [NUM_CH];
  logic [NUM_CH-1:0] sel_scon;
  logic [NUM_CH-1:0] ovr;
  logic [NUM_CH-1:0] ovr_nxt;
  logic [NUM_CH-1:0] ovr_set;
  logic [NUM_CH-1:0] ovr_clr;
  logic              sel_stat;
  logic              sel_id;
  logic              we;
  logic [CHW-1:0]    id_nxt;
  logic              valid_nxt;
  logic              cur_pending;
  logic              found;

  // Address decode for SCON channels and the two bank-wide registers.
  always_comb begin
    we       = !wr_n;
    sel_stat = (ab == STAT_ADDR);
    sel_id   = (ab == ID_ADDR);
    sel_scon = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sel_scon[i] = (ab == ADDR_W'(32'(SCON_BASE) + 2 * i));
    end
  end

  // Next SCON/overrun state: CPU write supplies bits 7:3, hardware events
  // override bits 2:0 so a flag raised during a write is never lost.
  always_comb begin
    logic       wr_i;
    logic [7:0] base;
    ovr_set = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_i = we && sel_scon[i];
      base = wr_i ? din : scon[i];
      scon_nxt[i] = base;
      if (ti[i])      scon_nxt[i][1] = 1'b1;
      if (ri[i])      scon_nxt[i][0] = 1'b1;
      if (set_rb8[i]) scon_nxt[i][2] = rb8[i];
      ovr_set[i] = ri[i] && scon[i][0] && !(wr_i && !din[0]);
    end
    ovr_clr = (we && sel_stat) ? din[NUM_CH-1:0] : '0;
    ovr_nxt = (ovr & ~ovr_clr) | ovr_set;
  end

  // Register bank and overrun flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) scon[i] <= '0;
      ovr <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) scon[i] <= scon_nxt[i];
      ovr <= ovr_nxt;
    end
  end

  // Fan SCON fields out to the per-channel control outputs.
  always_comb begin
    sm      = '0;
    sm2     = '0;
    ren     = '0;
    tb8     = '0;
    scon_ri = '0;
    int_ch  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sm[2*i +: 2] = scon[i][7:6];
      sm2[i]       = scon[i][5];
      ren[i]       = scon[i][4];
      tb8[i]       = scon[i][3];
      scon_ri[i]   = scon[i][0];
      int_ch[i]    = scon[i][1] | scon[i][0];
    end
    int_uart = |int_ch;
  end

  // Round-robin search: hold a still-pending grant, otherwise scan from the
  // channel after int_id, wrapping, and ending on int_id itself.
  always_comb begin
    int unsigned idx;
    cur_pending = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (int_id == CHW'(i)) cur_pending = int_ch[i];
    end
    id_nxt    = int_id;
    valid_nxt = 1'b0;
    found     = 1'b0;
    idx       = 0;
    if (int_valid && cur_pending) begin
      valid_nxt = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
        idx = (32'(int_id) + k) % NUM_CH;
        for (int unsigned j = 0; j < NUM_CH; j++) begin
          if (!found && (j == idx) && int_ch[j]) begin
            found  = 1'b1;
            id_nxt = CHW'(j);
          end
        end
      end
      valid_nxt = found;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_id    <= '0;
      int_valid <= 1'b0;
    end else begin
      int_id    <= id_nxt;
      int_valid <= valid_nxt;
    end
  end

  // SFR read mux; zero when nothing is selected or the read strobe is idle.
  always_comb begin
    dout = '0;
    if (!rd_n) begin
      if (sel_stat) dout[NUM_CH-1:0] = ovr;
      if (sel_id) begin
        dout[7]       = int_valid;
        dout[CHW-1:0] = int_id;
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (sel_scon[i]) dout = scon[i];
      end
    end
  end

endmodule

// File: tb/tb_uart_scon_bank.sv
// Directed bench for uart_scon_bank with two channels.
module tb_uart_scon_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic [7:0] ab;
  logic       rd_n;
  logic       wr_n;
  logic [1:0] ti;
  logic [1:0] ri;
  logic [1:0] set_rb8;
  logic [1:0] rb8;
  logic [7:0] dout;
  logic [3:0] sm;
  logic [1:0] sm2;
  logic [1:0] ren;
  logic [1:0] tb8;
  logic [1:0] scon_ri;
  logic [1:0] int_ch;
  logic       int_uart;
  logic [2:0] int_id;
  logic       int_valid;

  int checks = 0;
  int errors = 0;

  uart_scon_bank #(
    .NUM_CH(2),
    .ADDR_W(8),
    .SCON_BASE(8'h98),
    .STAT_ADDR(8'hA8),
    .ID_ADDR(8'hA9),
    .CHW(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .ab(ab), .rd_n(rd_n), .wr_n(wr_n),
    .ti(ti), .ri(ri), .set_rb8(set_rb8), .rb8(rb8), .dout(dout),
    .sm(sm), .sm2(sm2), .ren(ren), .tb8(tb8), .scon_ri(scon_ri),
    .int_ch(int_ch), .int_uart(int_uart), .int_id(int_id), .int_valid(int_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    ab   = addr;
    din  = data;
    wr_n = 1'b0;
    tick();
    wr_n = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    ab   = addr;
    rd_n = 1'b0;
    #1;
    chk(tag, dout, exp);
    rd_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; din = '0; ab = '0; rd_n = 1'b1; wr_n = 1'b1;
    ti = '0; ri = '0; set_rb8 = '0; rb8 = '0;
    #12;
    chk("reset_sm", 8'(sm), 8'h00);
    chk("reset_int", {5'b0, int_valid, int_ch}, 8'h00);
    rst_n = 1'b1;
    tick();

    // basic write / read / decode
    wr(8'h98, 8'h50);
    chk("sm_after_wr", 8'(sm), 8'h01);
    chk("ren_after_wr", 8'(ren), 8'h01);
    chk("sm2_after_wr", 8'(sm2), 8'h00);
    rd("rd_scon0", 8'h98, 8'h50);
    rd("rd_scon1", 8'h9A, 8'h00);
    rd("rd_unmapped", 8'h99, 8'h00);
    wr(8'h99, 8'hFF);
    rd("wr_unmapped_dropped", 8'h98, 8'h50);
    ab = 8'h98;
    #1;
    chk("dout_idle", dout, 8'h00);

    // ri[1] -> flag, then arbiter one clock later
    ri = 2'b10;
    tick();
    ri = 2'b00;
    chk("int_ch_ri1", 8'(int_ch), 8'h02);
    chk("int_uart_ri1", 8'(int_uart), 8'h01);
    chk("valid_lag", 8'(int_valid), 8'h00);
    tick();
    rd("id_ch1", 8'hA9, 8'h81);

    // clearing ch1 drops int_valid, int_id holds
    wr(8'h9A, 8'h00);
    tick();
    rd("id_none", 8'hA9, 8'h01);

    // overrun on ch0, W1C clear
    ri = 2'b01; tick();
    ri = 2'b01; tick();
    ri = 2'b00;
    rd("stat_ovr", 8'hA8, 8'h01);
    wr(8'hA8, 8'h01);
    rd("stat_clr", 8'hA8, 8'h00);

    // overrun set and W1C clear in the same cycle: set wins
    ab = 8'hA8; din = 8'h01; wr_n = 1'b0; ri = 2'b01;
    tick();
    wr_n = 1'b1; ri = 2'b00;
    rd("stat_set_wins", 8'hA8, 8'h01);
    wr(8'hA8, 8'h01);

    // write clearing bit0 together with ri: no overrun, bit0 stays set
    ab = 8'h98; din = 8'h50; wr_n = 1'b0; ri = 2'b01;
    tick();
    wr_n = 1'b1; ri = 2'b00;
    rd("wr_ri_scon", 8'h98, 8'h51);
    rd("wr_ri_no_ovr", 8'hA8, 8'h00);

    // ti overrides written bit1, RB8 load
    ab = 8'h9A; din = 8'h00; wr_n = 1'b0; ti = 2'b10;
    tick();
    wr_n = 1'b1; ti = 2'b00;
    rd("wr_ti_scon1", 8'h9A, 8'h02);
    set_rb8 = 2'b10; rb8 = 2'b10;
    tick();
    set_rb8 = 2'b00; rb8 = 2'b00;
    rd("rb8_load", 8'h9A, 8'h06);
    wr(8'h9A, 8'h00);
    tick();
    rd("id_ch0", 8'hA9, 8'h80);

    // round-robin fairness
    ti = 2'b10; tick(); ti = 2'b00;
    tick(); tick();
    rd("both_hold_ch0", 8'hA9, 8'h80);
    wr(8'h98, 8'h00);
    tick();
    rd("rr_to_ch1", 8'hA9, 8'h81);
    ri = 2'b01; tick(); ri = 2'b00;
    wr(8'h9A, 8'h00);
    tick();
    rd("rr_back_ch0", 8'hA9, 8'h80);

    // asynchronous reset mid-cycle with flags set
    ti = 2'b10; tick(); ti = 2'b00;
    ab = 8'h98; rd_n = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_dout", dout, 8'h00);
    chk("async_int_ch", 8'(int_ch), 8'h00);
    chk("async_int", {4'b0, int_id, int_valid}, 8'h00);
    chk("async_uart", 8'(int_uart), 8'h00);
    rd_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
